// File: rtl/bus_bridge_mc_pkg.sv
// Shared types and constants for the CPU-to-peripheral bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bus_bridge_mc_pkg;

    // Bridge FSM encoding. The encoding is fixed so that waveforms stay readable
    // across builds and so that external debug taps can decode the state.
    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_WAIT = 2'd1,
        BR_RESP = 2'd2
    } br_state_t;

    // Default peripheral windows (inclusive bounds).
    localparam logic [31:0] BR_DM_BASE    = 32'h0000_0000;
    localparam logic [31:0] BR_DM_LIMIT   = 32'h0000_2fff;
    localparam logic [31:0] BR_TMR0_BASE  = 32'h0000_7f00;
    localparam logic [31:0] BR_TMR0_LIMIT = 32'h0000_7f0b;
    localparam logic [31:0] BR_TMR1_BASE  = 32'h0000_7f10;
    localparam logic [31:0] BR_TMR1_LIMIT = 32'h0000_7f1b;

    localparam int BR_DEF_SLAVES = 3;

    // Width of a binary slave index; never narrower than one bit.
    function automatic int br_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_bridge_mc_addr_decoder.sv
// Address window decoder: priority (lowest index) hit, binary index, word-only legality.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle from the live CPU request.
module bridge_addr_decoder
    import bus_bridge_mc_pkg::*;
#(
    parameter int                         NUM_SLAVES  = BR_DEF_SLAVES,
    parameter int                         IDX_W       = br_idx_w(NUM_SLAVES),
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE  = {BR_TMR1_BASE, BR_TMR0_BASE, BR_DM_BASE},
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_LIMIT = {BR_TMR1_LIMIT, BR_TMR0_LIMIT, BR_DM_LIMIT},
    parameter logic [NUM_SLAVES-1:0]      WORD_ONLY   = 3'b110
) (
    input  logic [31:0]             addr,
    input  logic [3:0]              byteen,
    output logic [NUM_SLAVES-1:0]   hit,
    output logic [IDX_W-1:0]        idx,
    output logic                    any_hit,
    output logic                    illegal
);

    // Partial-word accesses are those that are neither a load nor a full-word store.
    logic partial_word;
    assign partial_word = (byteen != 4'b0000) && (byteen != 4'b1111);

    // Walk the windows from slave 0 upward; the first match wins. The window test
    // uses offset arithmetic (addr-base <= limit-base) so a zero base does not turn
    // into a tautological unsigned compare; the extra base<=limit guard keeps an
    // inverted window from ever matching.
    always_comb begin
        hit     = '0;
        idx     = '0;
        any_hit = 1'b0;
        illegal = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!any_hit
                && (SLAVE_BASE[i*32 +: 32] <= SLAVE_LIMIT[i*32 +: 32])
                && ((addr - SLAVE_BASE[i*32 +: 32])
                    <= (SLAVE_LIMIT[i*32 +: 32] - SLAVE_BASE[i*32 +: 32]))) begin
                hit[i]  = 1'b1;
                idx     = IDX_W'(i);
                any_hit = 1'b1;
                illegal = WORD_ONLY[i] && partial_word;
            end
        end
    end

endmodule

// File: rtl/bus_bridge_mc.sv
// Multi-cycle CPU memory-stage bridge to NUM_SLAVES peripherals (optional WAIT bound: BRIDGE_TIMEOUT_EN).
// Latency: 2 cycles minimum (request, WAIT with ready, RESP); errors on decode are flagged the next cycle.
// Backpressure: cpu_stall holds the pipeline while a slave access is pending; s_req held until s_ready.
module bus_bridge_mc
    import bus_bridge_mc_pkg::*;
#(
    parameter int                         NUM_SLAVES     = BR_DEF_SLAVES,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {BR_TMR1_BASE, BR_TMR0_BASE, BR_DM_BASE},
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_LIMIT    = {BR_TMR1_LIMIT, BR_TMR0_LIMIT, BR_DM_LIMIT},
    parameter logic [NUM_SLAVES-1:0]      WORD_ONLY      = 3'b110,
    parameter int                         TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cpu_req,
    input  logic [3:0]                  cpu_byteen,
    input  logic [31:0]                 cpu_addr,
    input  logic [31:0]                 cpu_wdata,
    output logic [31:0]                 cpu_rdata,
    output logic                        cpu_stall,
    output logic                        cpu_err,
    output logic [NUM_SLAVES-1:0]       s_req,
    output logic [31:0]                 s_addr,
    output logic [31:0]                 s_wdata,
    output logic [3:0]                  s_byteen,
    input  logic [NUM_SLAVES*32-1:0]    s_rdata,
    input  logic [NUM_SLAVES-1:0]       s_ready
);

    localparam int IDX_W = br_idx_w(NUM_SLAVES);

    br_state_t              state;
    br_state_t              state_nxt;

    logic [NUM_SLAVES-1:0]  dec_hit;
    logic [IDX_W-1:0]       dec_idx;
    logic                   dec_any_hit;
    logic                   dec_illegal;
    logic                   legal_hit;

    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_rdy;
    logic [31:0]            sel_dat;
    logic                   wait_expire;

    logic [NUM_SLAVES-1:0]  s_req_nxt;
    logic                   lat_en;
    logic                   rdata_ld;
    logic [31:0]            rdata_nxt;
    logic                   err_nxt;

    bridge_addr_decoder #(
        .NUM_SLAVES  (NUM_SLAVES),
        .IDX_W       (IDX_W),
        .SLAVE_BASE  (SLAVE_BASE),
        .SLAVE_LIMIT (SLAVE_LIMIT),
        .WORD_ONLY   (WORD_ONLY)
    ) u_dec (
        .addr    (cpu_addr),
        .byteen  (cpu_byteen),
        .hit     (dec_hit),
        .idx     (dec_idx),
        .any_hit (dec_any_hit),
        .illegal (dec_illegal)
    );

    assign legal_hit = dec_any_hit && !dec_illegal;

    // Select ready and read data of the latched slave; other slaves are ignored.
    always_comb begin
        sel_rdy = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_rdy = s_ready[i];
                sel_dat = s_rdata[i*32 +: 32];
            end
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] wait_cnt;

    // Count WAIT cycles already spent; restarts every time WAIT is entered.
    always_ff @(posedge clk) begin
        if (!reset_n || (state != BR_WAIT)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + TMR_W'(1);
        end
    end

    // The current WAIT cycle is the last one allowed: TIMEOUT_CYCLES-1 cycles are behind us.
    assign wait_expire = (state == BR_WAIT) && (wait_cnt == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    assign wait_expire = 1'b0;
`endif

    // Pipeline freeze: whole of WAIT, plus the request cycle of an access that will be issued.
    assign cpu_stall = (state == BR_WAIT) || ((state == BR_IDLE) && cpu_req && legal_hit);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= BR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control. A ready from the selected slave takes
    // precedence over the WAIT bound when both land in the same cycle.
    always_comb begin
        state_nxt = state;
        s_req_nxt = s_req;
        lat_en    = 1'b0;
        rdata_ld  = 1'b0;
        rdata_nxt = cpu_rdata;
        err_nxt   = 1'b0;
        case (state)
            BR_IDLE: begin
                s_req_nxt = '0;
                if (cpu_req) begin
                    if (legal_hit) begin
                        state_nxt = BR_WAIT;
                        s_req_nxt = dec_hit;
                        lat_en    = 1'b1;
                    end else begin
                        err_nxt   = 1'b1;
                        rdata_ld  = 1'b1;
                        rdata_nxt = '0;
                    end
                end
            end
            BR_WAIT: begin
                if (sel_rdy) begin
                    state_nxt = BR_RESP;
                    s_req_nxt = '0;
                    rdata_ld  = 1'b1;
                    rdata_nxt = sel_dat;
                end else if (wait_expire) begin
                    state_nxt = BR_RESP;
                    s_req_nxt = '0;
                    rdata_ld  = 1'b1;
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                end
            end
            BR_RESP: begin
                // The retiring instruction still shows cpu_req here; it is not a new access.
                state_nxt = BR_IDLE;
                s_req_nxt = '0;
            end
            default: begin
                state_nxt = BR_IDLE;
                s_req_nxt = '0;
            end
        endcase
    end

    // Slave-side request, latched access fields, CPU response registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_req     <= '0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_byteen  <= '0;
            sel_idx   <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
        end else begin
            s_req   <= s_req_nxt;
            cpu_err <= err_nxt;
            if (lat_en) begin
                s_addr   <= cpu_addr;
                s_wdata  <= cpu_wdata;
                s_byteen <= cpu_byteen;
                sel_idx  <= dec_idx;
            end
            if (rdata_ld) begin
                cpu_rdata <= rdata_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bus_bridge_mc.sv
// Bench for bus_bridge_mc: directed and randomized accesses against a transaction-level model.
// Latency: n/a.
// Backpressure: slave readiness is driven by the bench with randomized delays.
module tb_bus_bridge_mc;

    localparam int          TO      = 4;
    localparam logic [95:0] BASE    = {32'h7f10, 32'h7f00, 32'h0000};
    localparam logic [95:0] LIMIT   = {32'h7f1b, 32'h7f0b, 32'h2fff};
    localparam logic [95:0] OV_BASE = {32'h7f10, 32'h0000, 32'h0000};
    localparam logic [2:0]  WO      = 3'b110;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [95:0] s_rdata;
    logic [2:0]  s_ready;

    logic [31:0] cpu_rdata, ov_cpu_rdata;
    logic        cpu_stall, ov_cpu_stall;
    logic        cpu_err, ov_cpu_err;
    logic [2:0]  s_req, ov_s_req;
    logic [31:0] s_addr, ov_s_addr;
    logic [31:0] s_wdata, ov_s_wdata;
    logic [3:0]  s_byteen, ov_s_byteen;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata;

    bus_bridge_mc #(
        .NUM_SLAVES(3), .SLAVE_BASE(BASE), .SLAVE_LIMIT(LIMIT),
        .WORD_ONLY(WO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_byteen(cpu_byteen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_err(cpu_err), .s_req(s_req), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_byteen(s_byteen), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    bus_bridge_mc #(
        .NUM_SLAVES(3), .SLAVE_BASE(OV_BASE), .SLAVE_LIMIT(LIMIT),
        .WORD_ONLY(WO), .TIMEOUT_CYCLES(TO)
    ) dut_ov (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_byteen(cpu_byteen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(ov_cpu_rdata),
        .cpu_stall(ov_cpu_stall), .cpu_err(ov_cpu_err), .s_req(ov_s_req), .s_addr(ov_s_addr),
        .s_wdata(ov_s_wdata), .s_byteen(ov_s_byteen), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    // Reference decode: first window (lowest index) containing the address; -1 for miss or illegal.
    function automatic int ref_decode(input logic [31:0] a, input logic [3:0] be,
                                      input logic [95:0] b, input logic [95:0] l,
                                      input logic [2:0] wo);
        for (int i = 0; i < 3; i++) begin
            if (a >= b[i*32 +: 32] && a <= l[i*32 +: 32]) begin
                if (wo[i] && be != 4'h0 && be != 4'hf) return -1;
                return i;
            end
        end
        return -1;
    endfunction

    // Reference WAIT bound: an access whose ready comes later than the bound times out.
    function automatic bit ref_times_out(input int d);
`ifdef BRIDGE_TIMEOUT_EN
        return d > TO;
`else
        return (d < 0);
`endif
    endfunction

    // One CPU access; slave ready asserted in WAIT cycle d (1 = the cycle right after the request).
    task automatic run_txn(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                           input int d, input string nm);
        int          idx;
        bit          to;
        int          nw;
        logic [31:0] rd;
        logic [2:0]  exp_req;
        idx = ref_decode(a, be, BASE, LIMIT, WO);
        rd  = $urandom;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = a; cpu_byteen = be; cpu_wdata = wd;
        s_ready = 3'($urandom);
        s_rdata = {$urandom, $urandom, $urandom};
        @(negedge clk);
        n_chk++;
        if (cpu_stall !== (idx >= 0)) begin
            n_fail++; $display("FAIL %s req_stall: got %0b want %0b", nm, cpu_stall, (idx >= 0));
        end
        n_chk++;
        if (s_req !== 3'b000) begin
            n_fail++; $display("FAIL %s req_sreq: got %b want 000", nm, s_req);
        end
        if (idx < 0) begin
            @(posedge clk); #1;
            cpu_req = 1'b0; s_ready = 3'b000;
            exp_rdata = 32'h0;
            @(negedge clk);
            n_chk++;
            if ({cpu_err, cpu_stall, s_req} !== 5'b10000) begin
                n_fail++; $display("FAIL %s reject: got err=%0b stall=%0b sreq=%b want err=1 stall=0 sreq=000",
                                   nm, cpu_err, cpu_stall, s_req);
            end
            n_chk++;
            if (cpu_rdata !== exp_rdata) begin
                n_fail++; $display("FAIL %s reject_rdata: got %h want %h", nm, cpu_rdata, exp_rdata);
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_chk++;
            if (cpu_err !== 1'b0) begin
                n_fail++; $display("FAIL %s err_pulse: got %0b want 0", nm, cpu_err);
            end
            return;
        end
        to      = ref_times_out(d);
        nw      = to ? TO : d;
        exp_req = 3'b001 << idx;
        for (int k = 1; k <= nw; k++) begin
            @(posedge clk); #1;
            s_rdata = {$urandom, $urandom, $urandom};
            s_ready = 3'($urandom);
            s_ready[idx] = (k == d);
            if (k == d) s_rdata[idx*32 +: 32] = rd;
            @(negedge clk);
            n_chk++;
            if ({s_req, cpu_stall} !== {exp_req, 1'b1}) begin
                n_fail++; $display("FAIL %s wait%0d: got sreq=%b stall=%0b want sreq=%b stall=1",
                                   nm, k, s_req, cpu_stall, exp_req);
            end
            n_chk++;
            if ({s_addr, s_wdata, s_byteen} !== {a, wd, be}) begin
                n_fail++; $display("FAIL %s wait%0d_fields: got %h/%h/%h want %h/%h/%h",
                                   nm, k, s_addr, s_wdata, s_byteen, a, wd, be);
            end
        end
        @(posedge clk); #1;
        s_ready   = 3'($urandom);
        exp_rdata = to ? 32'h0 : rd;
        @(negedge clk);
        n_chk++;
        if ({cpu_stall, s_req, cpu_err} !== {1'b0, 3'b000, to}) begin
            n_fail++; $display("FAIL %s resp: got stall=%0b sreq=%b err=%0b want stall=0 sreq=000 err=%0b",
                               nm, cpu_stall, s_req, cpu_err, to);
        end
        n_chk++;
        if (cpu_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL %s resp_rdata: got %h want %h", nm, cpu_rdata, exp_rdata);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; s_ready = 3'b000;
        @(negedge clk);
        n_chk++;
        if ({cpu_stall, s_req, cpu_err} !== 5'b00000 || cpu_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL %s idle_after: got stall=%0b sreq=%b err=%0b rdata=%h want 0/000/0/%h",
                               nm, cpu_stall, s_req, cpu_err, cpu_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cpu_req = 1'b0; cpu_byteen = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        s_rdata = {$urandom, $urandom, $urandom}; s_ready = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({s_req, cpu_stall, cpu_err} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_ctrl: got sreq=%b stall=%0b err=%0b want 000/0/0", s_req, cpu_stall, cpu_err);
        end
        n_chk++;
        if ({s_addr, s_wdata, s_byteen, cpu_rdata} !== 100'h0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h want zeros", s_addr, s_wdata, s_byteen, cpu_rdata);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; s_ready = 3'b000;
        exp_rdata = 32'h0;
    endtask

    // Second instance has slave 0 and slave 1 both based at 0: the lower index must win.
    task automatic test_overlap();
        logic [31:0] v;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 32'h1000; cpu_byteen = 4'h0; s_ready = 3'b000;
        @(posedge clk); #1;
        s_rdata = {$urandom, $urandom, $urandom}; s_ready = 3'b111;
        exp_rdata = s_rdata[31:0];
        @(negedge clk);
        n_chk++;
        if (ov_s_req !== 3'b001) begin
            n_fail++; $display("FAIL overlap_prio: got %b want 001", ov_s_req);
        end
        @(posedge clk); #1;
        s_ready = 3'b000;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 32'h3000; cpu_byteen = 4'hf;
        @(posedge clk); #1;
        v = $urandom;
        cpu_req = 1'b0; s_ready = 3'b111; s_rdata[63:32] = v;
        exp_rdata = 32'h0;
        @(negedge clk);
        n_chk++;
        if ({ov_s_req, ov_cpu_stall, cpu_err} !== {3'b010, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL overlap_win1: got ovsreq=%b ovstall=%0b err=%0b want 010/1/1",
                               ov_s_req, ov_cpu_stall, cpu_err);
        end
        @(posedge clk); #1;
        s_ready = 3'b000;
        @(negedge clk);
        n_chk++;
        if ({ov_cpu_rdata, ov_cpu_err, ov_cpu_stall} !== {v, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL overlap_resp: got rdata=%h err=%0b stall=%0b want %h/0/0",
                               ov_cpu_rdata, ov_cpu_err, ov_cpu_stall, v);
        end
        n_chk++;
        if (cpu_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL overlap_main_rdata: got %h want %h", cpu_rdata, exp_rdata);
        end
    endtask

    task automatic test_directed();
        run_txn(32'h0000_1000, 4'h0, 32'h0, 1, "dm_load");
        run_txn(32'h0000_7f04, 4'hf, 32'hcafe_f00d, 3, "tmr0_sw");
        run_txn(32'h0000_7f14, 4'h2, 32'h55, 1, "tmr1_sb_illegal");
        run_txn(32'h0000_5000, 4'h0, 32'h0, 1, "unmapped");
        run_txn(32'h0000_2fff, 4'h1, 32'h12, 2, "dm_top_sb");
        run_txn(32'h0000_3000, 4'h0, 32'h0, 1, "dm_above");
        run_txn(32'h0000_7f0b, 4'h0, 32'h0, 1, "tmr0_top");
        run_txn(32'h0000_7f0c, 4'h0, 32'h0, 1, "tmr0_above");
        run_txn(32'h0000_7f1b, 4'hf, 32'h9, 2, "tmr1_top");
        run_txn(32'h0000_7f1c, 4'hf, 32'h9, 1, "tmr1_above");
        run_txn(32'h0000_7f00, 4'h3, 32'h9, 1, "tmr0_half");
    endtask

    task automatic test_wait_bound();
`ifdef BRIDGE_TIMEOUT_EN
        run_txn(32'h0000_7f08, 4'h0, 32'h0, 20, "timeout");
        run_txn(32'h0000_7f08, 4'h0, 32'h0, TO, "ready_at_limit");
        run_txn(32'h0000_0040, 4'h0, 32'h0, TO + 1, "timeout_dm");
`else
        run_txn(32'h0000_7f08, 4'h0, 32'h0, 12, "long_wait");
        run_txn(32'h0000_7f08, 4'h0, 32'h0, TO + 1, "past_bound");
`endif
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 32'h0000_0100; cpu_byteen = 4'h0; s_ready = 3'b000;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++;
        if (s_req !== 3'b001) begin
            n_fail++; $display("FAIL rstmid_pre: got %b want 001", s_req);
        end
        @(posedge clk); #1;
        reset_n = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; s_ready = 3'b111;
        exp_rdata = 32'h0;
        @(negedge clk);
        n_chk++;
        if ({s_req, cpu_stall, cpu_err} !== 5'b00000 || cpu_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL rstmid: got sreq=%b stall=%0b err=%0b rdata=%h want 000/0/0/%h",
                               s_req, cpu_stall, cpu_err, cpu_rdata, exp_rdata);
        end
        @(posedge clk); #1;
        s_ready = 3'b000;
        @(negedge clk);
        n_chk++;
        if ({s_req, cpu_err} !== 4'b0000 || cpu_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL rstmid_noresp: got sreq=%b err=%0b rdata=%h want 000/0/%h",
                               s_req, cpu_err, cpu_rdata, exp_rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [3:0]  be;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0:       a = $urandom_range(0, 32'h2fff);
                1:       a = 32'h7f00 + $urandom_range(0, 11);
                2:       a = 32'h7f10 + $urandom_range(0, 11);
                3:       a = $urandom_range(32'h3000, 32'h7eff);
                4:       a = 32'h7f0c + $urandom_range(0, 3);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0:       be = 4'h0;
                1:       be = 4'hf;
                default: be = 4'($urandom);
            endcase
            run_txn(a, be, $urandom, $urandom_range(1, 6), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_overlap();
        test_directed();
        test_wait_bound();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
